axi_aw_w_burst_tracker: RTL and testbench

// - Write-channel burst tracker; sits downstream of the AXI4 write-address channel, alongside the W channel.
// - Queues each accepted AW {AWID, AWLEN}, then counts W beats against the head entry.
// - Pulses error flags on WLAST mismatch, queue overflow and orphan W beats.
// - Monitor only: never drives READY/VALID; outputs feed the scoreboard and the assertion interface.

---
 rtl/axi_aw_w_burst_tracker.sv | 139 +++++++++++++
 tb/tb_axi_aw_w_burst_tracker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/axi_aw_w_burst_tracker.sv
// rtl/axi_aw_w_burst_tracker.sv - AXI4 AW/W burst tracker (optional 4KB check: AXI_AW_4KB_CHECK_EN)
module axi_aw_w_burst_tracker #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     AWCLK,
    input  logic                     ARESET,
    input  logic                     AWVALID,
    input  logic                     AWREADY,
    input  logic [ADDR_WIDTH-1:0]    AWADDR,
    input  logic [ID_WIDTH-1:0]      AWID,
    input  logic [LEN_WIDTH-1:0]     AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     WVALID,
    input  logic                     WREADY,
    input  logic                     WLAST,
    output logic [ID_WIDTH-1:0]      cur_wid,
    output logic                     cur_wid_vld,
    output logic [LEN_WIDTH-1:0]     beat_cnt,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_wlast_early,
    output logic                     err_wlast_missing,
    output logic                     err_overflow,
    output logic                     err_w_orphan,
    output logic                     err_4kb
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]          FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state, state_nxt;
    logic [ID_WIDTH-1:0]   id_q  [DEPTH];
    logic [LEN_WIDTH-1:0]  len_q [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_nxt;
    logic [PW:0]           cnt_nxt;
    logic [ID_WIDTH-1:0]   wid_nxt;
    logic [LEN_WIDTH-1:0]  head_len;
    logic aw_hs, w_hs, q_empty, q_full, w_bound, close, push;

    // Handshake decode; with an empty queue the beat binds to a same-cycle AW
    always_comb begin
        aw_hs    = AWVALID & AWREADY;
        w_hs     = WVALID & WREADY;
        q_empty  = (outstanding == '0);
        q_full   = (outstanding == FULL_CNT);
        head_len = q_empty ? AWLEN : len_q[rd_ptr];
        w_bound  = w_hs & (~q_empty | aw_hs);
        close    = w_bound & (WLAST | (beat_cnt == head_len));
        push     = aw_hs & (~q_full | close);
        cnt_nxt  = outstanding + (PW+1)'(push) - (PW+1)'(close);
        rd_nxt   = rd_ptr + PW'(close);
        wid_nxt  = '0;
        if (cnt_nxt != '0) begin
            // the slot being written becomes head when nothing older survives the pop
            if (push && (rd_nxt == wr_ptr)) wid_nxt = AWID;
            else                            wid_nxt = id_q[rd_nxt];
        end
    end

    // Burst FSM next state: IDLE until the first non-closing beat of a burst
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (w_bound & ~close) state_nxt = BURST;
            BURST:   if (close)            state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Queue storage; no reset needed since pointers define validity
    always_ff @(posedge AWCLK) begin
        if (!ARESET && push) begin
            id_q[wr_ptr]  <= AWID;
            len_q[wr_ptr] <= AWLEN;
        end
    end

    // Pointers, counters, registered head view and error pulses
    always_ff @(posedge AWCLK) begin
        if (ARESET) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            outstanding       <= '0;
            beat_cnt          <= '0;
            cur_wid           <= '0;
            cur_wid_vld       <= 1'b0;
            err_wlast_early   <= 1'b0;
            err_wlast_missing <= 1'b0;
            err_overflow      <= 1'b0;
            err_w_orphan      <= 1'b0;
        end else begin
            state             <= state_nxt;
            if (push) wr_ptr  <= wr_ptr + PW'(1);
            rd_ptr            <= rd_nxt;
            outstanding       <= cnt_nxt;
            cur_wid           <= wid_nxt;
            cur_wid_vld       <= (cnt_nxt != '0);
            if (close)        beat_cnt <= '0;
            else if (w_bound) beat_cnt <= beat_cnt + LEN_ONE;
            err_wlast_early   <= w_bound & WLAST & (beat_cnt < head_len);
            err_wlast_missing <= w_bound & ~WLAST & (beat_cnt == head_len);
            err_overflow      <= aw_hs & ~push;
            err_w_orphan      <= w_hs & q_empty & ~aw_hs;
        end
    end

`ifdef AXI_AW_4KB_CHECK_EN
    logic [ADDR_WIDTH:0] xfer_bytes, end_addr;
    logic                flag_4kb;

    // Last byte of an INCR burst must share the start address's 4KB page
    always_comb begin
        xfer_bytes = ((ADDR_WIDTH+1)'(AWLEN) + (ADDR_WIDTH+1)'(1)) << AWSIZE;
        end_addr   = {1'b0, AWADDR} + xfer_bytes - (ADDR_WIDTH+1)'(1);
        flag_4kb   = (AWBURST == 2'b11) ||
                     ((AWBURST == 2'b01) &&
                      (end_addr[ADDR_WIDTH] ||
                       (AWADDR[ADDR_WIDTH-1:12] != end_addr[ADDR_WIDTH-1:12])));
    end

    // One-cycle pulse after an offending AW handshake
    always_ff @(posedge AWCLK) begin
        if (ARESET) err_4kb <= 1'b0;
        else        err_4kb <= aw_hs & flag_4kb;
    end
`else
    logic unused_4kb_inputs;
    assign unused_4kb_inputs = ^{AWADDR, AWSIZE, AWBURST};
    assign err_4kb = 1'b0;
`endif

endmodule

// File: tb/tb_axi_aw_w_burst_tracker.sv
// tb/tb_axi_aw_w_burst_tracker.sv - scoreboard bench for axi_aw_w_burst_tracker
module tb_axi_aw_w_burst_tracker;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWVALID = 1'b0, AWREADY = 1'b0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWID = '0;
    logic [7:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = '0;
    logic [1:0]  AWBURST = '0;
    logic        WVALID = 1'b0, WREADY = 1'b0, WLAST = 1'b0;
    logic [3:0]  cur_wid;
    logic        cur_wid_vld;
    logic [7:0]  beat_cnt;
    logic [3:0]  outstanding;
    logic        err_wlast_early, err_wlast_missing, err_overflow, err_w_orphan, err_4kb;

    always #5 clk = ~clk;

    axi_aw_w_burst_tracker #(.ADDR_WIDTH(32), .ID_WIDTH(4), .LEN_WIDTH(8), .DEPTH(DEPTH)) dut (
        .AWCLK(clk), .ARESET(ARESET), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
        .cur_wid(cur_wid), .cur_wid_vld(cur_wid_vld), .beat_cnt(beat_cnt),
        .outstanding(outstanding), .err_wlast_early(err_wlast_early),
        .err_wlast_missing(err_wlast_missing), .err_overflow(err_overflow),
        .err_w_orphan(err_w_orphan), .err_4kb(err_4kb));

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] len;
    } ent_t;

    typedef struct packed {
        logic [3:0] cur_wid;
        logic       vld;
        logic [7:0] beat;
        logic [3:0] outst;
        logic       early, missing, ovf, orphan, e4k;
    } exp_t;

    ent_t mq[$];
    exp_t eq[$];
    int   beat = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit cross_4k(input logic [31:0] addr, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst);
        longint unsigned last_byte;
        last_byte = longint'(addr) + ((longint'(len) + 1) << size) - 1;
        if (burst == 2'b11) return 1'b1;
        if (burst == 2'b01 && (last_byte >> 12) != (longint'(addr) >> 12)) return 1'b1;
        return 1'b0;
    endfunction

    // Apply one cycle of stimulus and record what the spec says must follow it
    task automatic drive(input bit rst, input bit awv, input bit awr, input logic [3:0] id,
                         input logic [7:0] len, input logic [31:0] addr, input logic [2:0] size,
                         input logic [1:0] burst, input bit wv, input bit wr, input bit wl);
        exp_t e;
        ent_t ne;
        bit   aw, w, closed;
        int   hlen;
        @(negedge clk);
        ARESET = rst; AWVALID = awv; AWREADY = awr; AWID = id; AWLEN = len;
        AWADDR = addr; AWSIZE = size; AWBURST = burst;
        WVALID = wv; WREADY = wr; WLAST = wl;
        e = '0;
        aw = awv && awr;
        w = wv && wr;
        closed = 1'b0;
        if (rst) begin
            mq.delete();
            beat = 0;
        end else begin
            if (w) begin
                if (mq.size() == 0 && !aw) e.orphan = 1'b1;
                else begin
                    hlen = (mq.size() != 0) ? int'(mq[0].len) : int'(len);
                    if (wl && beat < hlen) e.early = 1'b1;
                    if (!wl && beat == hlen) e.missing = 1'b1;
                    closed = wl || (beat == hlen);
                    beat = closed ? 0 : beat + 1;
                end
            end
            if (aw) begin
                if (mq.size() < DEPTH || closed) begin
                    ne.id = id;
                    ne.len = len;
                    mq.push_back(ne);
                end else e.ovf = 1'b1;
`ifdef AXI_AW_4KB_CHECK_EN
                e.e4k = cross_4k(addr, len, size, burst);
`endif
            end
            if (closed) void'(mq.pop_front());
        end
        e.cur_wid = (mq.size() != 0) ? mq[0].id : 4'd0;
        e.vld     = (mq.size() != 0);
        e.beat    = 8'(beat);
        e.outst   = 4'(mq.size());
        eq.push_back(e);
    endtask

    task automatic idle_c();                 drive(0,0,0,0,0,0,0,1,0,0,0); endtask
    task automatic aw_c(input logic [3:0] id, input logic [7:0] len);
        drive(0,1,1,id,len,32'h1000,0,1,0,0,0);
    endtask
    task automatic w_c(input bit wl);        drive(0,0,0,0,0,0,0,1,1,1,wl); endtask
    task automatic aw_w_c(input logic [3:0] id, input logic [7:0] len, input bit wl);
        drive(0,1,1,id,len,32'h1000,0,1,1,1,wl);
    endtask

    // Monitor: every cycle's registered outputs are checked against the oldest expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("cur_wid", 32'(cur_wid), 32'(e.cur_wid));
            chk("cur_wid_vld", 32'(cur_wid_vld), 32'(e.vld));
            chk("beat_cnt", 32'(beat_cnt), 32'(e.beat));
            chk("outstanding", 32'(outstanding), 32'(e.outst));
            chk("err_wlast_early", 32'(err_wlast_early), 32'(e.early));
            chk("err_wlast_missing", 32'(err_wlast_missing), 32'(e.missing));
            chk("err_overflow", 32'(err_overflow), 32'(e.ovf));
            chk("err_w_orphan", 32'(err_w_orphan), 32'(e.orphan));
            chk("err_4kb", 32'(err_4kb), 32'(e.e4k));
        end
    end

    initial begin
        bit         rst, wl;
        logic [31:0] addr;
        drive(1,0,0,0,0,0,0,0,0,0,0);
        drive(1,0,0,0,0,0,0,0,0,0,0);
        // nominal 4-beat burst
        aw_c(4'd3, 8'd3);
        w_c(0); w_c(0); w_c(0); w_c(1);
        idle_c();
        // early WLAST then clean single beat
        aw_c(4'd1, 8'd3);
        w_c(0); w_c(1);
        aw_c(4'd2, 8'd0);
        w_c(1);
        // missing WLAST
        aw_c(4'd4, 8'd1);
        w_c(0); w_c(0);
        idle_c();
        // overflow, then full + push + pop
        for (int i = 0; i < 9; i++) aw_c(4'(i), 8'd0);
        aw_w_c(4'd9, 8'd0, 1'b1);
        for (int i = 0; i < 8; i++) w_c(1);
        idle_c();
        // bypass then orphan
        aw_w_c(4'd5, 8'd0, 1'b1);
        w_c(1);
        idle_c();
        // 4KB cases, then reset mid-burst
        drive(0,1,1,4'd6,8'd3,32'h0000_0FF0,3'd3,2'b01,0,0,0);
        drive(0,1,1,4'd7,8'd3,32'h0000_0FE0,3'd3,2'b01,0,0,0);
        drive(0,1,1,4'd8,8'd3,32'h0000_0FE0,3'd3,2'b11,0,0,0);
        drive(0,1,1,4'd9,8'd0,32'hFFFF_FFF8,3'd4,2'b01,0,0,0);
        w_c(0);
        drive(1,0,0,0,0,0,0,0,1,1,0);
        idle_c();
        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (mq.size() != 0 && $urandom_range(0, 7) != 0) wl = (beat == int'(mq[0].len));
            else wl = 1'($urandom);
            addr = ($urandom_range(0, 1) == 0) ? $urandom : (32'h0000_0F00 | 32'($urandom_range(0, 255)));
            drive(rst, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0), 4'($urandom),
                  8'($urandom_range(0, 5)), addr, 3'($urandom), 2'($urandom),
                  ($urandom_range(0, 1) == 0), ($urandom_range(0, 3) != 0), wl);
        end
        idle_c();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(eq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
